lcd_bus_arbiter: RTL and testbench
==================================

// Module: lcd_bus_arbiter
// PURPOSE
//  Shares one QC12864B-style 8-bit parallel LCD bus (RS/RW/E/DATA, write-only) between two requesters,
//  e.g. an init sequencer (req0) and a text/char writer (req1). Grants one transfer at a time,
//  generates E timing from mclk, and enforces per-command execution delays.
//  Sits between the LCD content logic and the LCD pins.
// PARAMETERS
//  T_PWRUP   2_000_000  cycles after reset before first grant (40 ms @ 50 MHz)
//  T_SU      4          RS/DATA setup cycles before E rises
//  T_PW      25         E high width, cycles
//  T_HD      4          RS/DATA hold cycles after E falls
//  T_EXEC    3_600      post-write wait, normal command or data (72 us)
//  T_CLR     80_000     post-write wait for CLEAR 8'h01 / HOME 8'h02 with rs=0 (1.6 ms)
// PORTS
//  mclk         in   1  system clock
//  rst          in   1  synchronous reset, active high
//  req0_valid   in   1  requester 0 has a transfer
//  req0_rs      in   1  0 = instruction, 1 = data
//  req0_data    in   8  byte to write
//  req0_lock    in   1  keep bus for next transfer (sampled at accept)
//  req0_ready   out  1  transfer accepted when valid && ready at posedge
//  req0_done    out  1  one-cycle pulse when that transfer's exec wait ends
//  req1_*       --   -  identical set for requester 1
//  busy         out  1  high in every state except IDLE
//  lcd_rs       out  1  register select
//  lcd_rw       out  1  tied 0
//  lcd_e        out  1  enable strobe
//  lcd_data     out  8  data bus
// BEHAVIOUR
//  Reset values: state=PWRUP, lcd_e=0, lcd_rs=0, lcd_data=8'h00, lcd_rw=0, readys=0, dones=0,
//   busy=1, rr_last=1 (req0 wins first tie), lock_owner=none.
//  FSM: PWRUP -(T_PWRUP cycles)-> IDLE -(accept)-> SETUP(T_SU) -> PULSE(T_PW) -> HOLD(T_HD)
//   -> EXEC(T_EXEC or T_CLR) -> IDLE. One down-counter (24 bit) loaded on each state entry.
//  reqN_ready: combinational, high only in IDLE for the arbitration winner with reqN_valid=1.
//  Arbitration in IDLE: lock_owner set -> only owner eligible, other waits even if valid.
//   Else one valid -> it wins; both valid -> the one != rr_last wins. rr_last updates on accept.
//  On accept: capture rs/data/lock into regs; lock_owner = lock ? winner : none.
//  lcd_rs/lcd_data: driven from capture regs at entry to SETUP, stable through SETUP/PULSE/HOLD,
//   retain last value in EXEC and IDLE.
//  lcd_e: 1 exactly T_PW cycles (PULSE only); 0 elsewhere.
//  Exec select: rs=0 && data in {8'h01,8'h02} -> T_CLR; all else -> T_EXEC.
//  reqN_done: pulse in the cycle state returns to IDLE, for the owner of that transfer only.
//  Min accept-to-accept spacing: T_SU+T_PW+T_HD+Texec+1 cycles (>=1 IDLE cycle).
//  Requester dropping valid before accept: no transfer, no side effect. Valid after accept ignored
//   until next IDLE.
//  rst asserted in any state: next edge returns to reset values (E low immediately, PWRUP restarts).
//  Parameters of value 0 are illegal; minimum 1 cycle each.
// STRUCTURE
//  lcd_pkg: state encodings, LCD_CMD_CLEAR=8'h01, LCD_CMD_HOME=8'h02, counter width 24.
//  Sub-module lcd_delay_cnt: loadable 24-bit down-counter with zero flag, reused per state.
//  Arbiter + FSM + capture regs in this module.
// TESTING (T_PWRUP=10, T_SU=2, T_PW=3, T_HD=2, T_EXEC=5, T_CLR=20)
//  1 Reset then req0 {rs=0,8'h30} at t0 -> no ready for 10 cycles; E high 3 cycles, data=8'h30 ready-to-E 2 cycles, done0 after 12.
//  2 req0 8'h01 rs=0 -> EXEC lasts 20 cycles; rs=1 8'h01 -> EXEC 5 cycles.
//  3 req0/req1 both valid continuously -> grants alternate 0,1,0,1; no E overlap.
//  4 req1 lock=1 on 8'h80 then 8'h41 lock=0, req0 valid throughout -> req1,req1,req0 order.
//  5 rst asserted mid-PULSE -> lcd_e=0 next edge, busy=1, 10-cycle PWRUP repeats, no done pulse.
//  6 req0 valid drops before ready -> no E pulse, state stays IDLE.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the QC12864B-style LCD bus arbiter.
// Holds the state encoding, the transfer payload and the long-command decode.
package lcd_pkg;

  localparam int unsigned CNT_W = 24;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic       lock;
  } xfer_t;

  // CLEAR and HOME instructions need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter shared by all timed states of the LCD bus FSM.
// Holds at zero; zero_c flags the last cycle of the current state.
module lcd_delay_cnt
  import lcd_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter for a write-only 8-bit parallel LCD bus.
// Grants one transfer at a time, generates E timing and per-command execution waits.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 2_000_000,
  parameter int unsigned T_SU    = 4,
  parameter int unsigned T_PW    = 25,
  parameter int unsigned T_HD    = 4,
  parameter int unsigned T_EXEC  = 3_600,
  parameter int unsigned T_CLR   = 80_000
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  input  logic       req0_lock,
  output logic       req0_ready,
  output logic       req0_done,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  input  logic       req1_lock,
  output logic       req1_ready,
  output logic       req1_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  state_t           state, state_next;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             grant0, grant1, accept;
  logic             rr_last, lock_vld, lock_id, owner;
  xfer_t            req0_x, req1_x, win_x;

  assign req0_x = '{rs: req0_rs, data: req0_data, lock: req0_lock};
  assign req1_x = '{rs: req1_rs, data: req1_data, lock: req1_lock};
  assign win_x  = grant1 ? req1_x : req0_x;

  // Lock owner is exclusive; otherwise round-robin on ties.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == ST_IDLE) begin
      if (lock_vld) begin
        grant0 = req0_valid && !lock_id;
        grant1 = req1_valid && lock_id;
      end else if (req0_valid && req1_valid) begin
        grant0 = rr_last;
        grant1 = !rr_last;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;
  assign lcd_rw     = 1'b0;

  lcd_delay_cnt #(
    .RST_VAL (CNT_W'(T_PWRUP - 1))
  ) u_cnt (
    .clk      (mclk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero_c   (cnt_zero)
  );

  always_ff @(posedge mclk) begin
    if (rst) begin
      state <= ST_PWRUP;
    end else begin
      state <= state_next;
    end
  end

  // Each timed state reloads the counter with its length minus one on entry.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    unique case (state)
      ST_PWRUP: begin
        if (cnt_zero) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SETUP;
          cnt_load   = 1'b1;
          cnt_val    = CNT_W'(T_SU - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_next = ST_PULSE;
          cnt_load   = 1'b1;
          cnt_val    = CNT_W'(T_PW - 1);
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_next = ST_HOLD;
          cnt_load   = 1'b1;
          cnt_val    = CNT_W'(T_HD - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_next = ST_EXEC;
          cnt_load   = 1'b1;
          cnt_val    = is_long_cmd(lcd_rs, lcd_data) ? CNT_W'(T_CLR - 1) : CNT_W'(T_EXEC - 1);
        end
      end
      ST_EXEC: begin
        if (cnt_zero) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_PWRUP;
      end
    endcase
  end

  // Bus pins, status and arbitration bookkeeping.
  always_ff @(posedge mclk) begin
    if (rst) begin
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      busy      <= 1'b1;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      rr_last   <= 1'b1;
      lock_vld  <= 1'b0;
      lock_id   <= 1'b0;
      owner     <= 1'b0;
    end else begin
      lcd_e     <= (state_next == ST_PULSE);
      busy      <= (state_next != ST_IDLE);
      req0_done <= (state == ST_EXEC) && cnt_zero && !owner;
      req1_done <= (state == ST_EXEC) && cnt_zero && owner;
      if (accept) begin
        lcd_rs   <= win_x.rs;
        lcd_data <= win_x.data;
        rr_last  <= grant1;
        owner    <= grant1;
        lock_vld <= win_x.lock;
        lock_id  <= grant1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: directed scenarios followed by random traffic,
// compared every cycle against a transaction-timeline model of the bus.
module tb_lcd_bus_arbiter;

  localparam int P_PWRUP = 10;
  localparam int P_SU    = 2;
  localparam int P_PW    = 3;
  localparam int P_HD    = 2;
  localparam int P_EXEC  = 5;
  localparam int P_CLR   = 20;

  logic       mclk;
  logic       rst;
  logic       req0_valid, req0_rs, req0_lock, req0_ready, req0_done;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_lock, req1_ready, req1_done;
  logic [7:0] req1_data;
  logic       busy, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  int tests = 0;
  int fails = 0;

  // Model: edges since last reset edge, plus the most recent accepted transfer.
  int         t;
  bit         act;
  int         k_acc;
  int         dur;
  bit         own;
  bit         m_rr;
  bit         m_lkv;
  bit         m_lkid;
  logic       m_rs;
  logic [7:0] m_data;
  bit         last_acc;
  bit         last_w;

  lcd_bus_arbiter #(
    .T_PWRUP (P_PWRUP),
    .T_SU    (P_SU),
    .T_PW    (P_PW),
    .T_HD    (P_HD),
    .T_EXEC  (P_EXEC),
    .T_CLR   (P_CLR)
  ) dut (
    .mclk       (mclk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_rs    (req0_rs),
    .req0_data  (req0_data),
    .req0_lock  (req0_lock),
    .req0_ready (req0_ready),
    .req0_done  (req0_done),
    .req1_valid (req1_valid),
    .req1_rs    (req1_rs),
    .req1_data  (req1_data),
    .req1_lock  (req1_lock),
    .req1_ready (req1_ready),
    .req1_done  (req1_done),
    .busy       (busy),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .lcd_data   (lcd_data)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h at t=%0d", tag, obs, exp, t);
    end
  endtask

  function automatic bit m_idle();
    return (t >= P_PWRUP) && (!act || (t - k_acc) >= dur);
  endfunction

  task automatic model_reset();
    t = 0; act = 1'b0; k_acc = 0; dur = 0; own = 1'b0;
    m_rr = 1'b1; m_lkv = 1'b0; m_lkid = 1'b0; m_rs = 1'b0; m_data = 8'h00;
  endtask

  // One clock: check ready before the edge, advance the model, check registered outputs after.
  task automatic cycle();
    bit         idle, e0, e1, lk, rs_w, rst_s;
    logic [7:0] dat;
    int         d;
    #1;
    idle = m_idle();
    e0 = idle && req0_valid && (m_lkv ? !m_lkid : (!req1_valid || m_rr));
    e1 = idle && req1_valid && (m_lkv ?  m_lkid : (!req0_valid || !m_rr));
    chk("ready0", 8'(req0_ready), 8'(e0));
    chk("ready1", 8'(req1_ready), 8'(e1));
    rst_s = rst;
    lk    = e1 ? req1_lock : req0_lock;
    rs_w  = e1 ? req1_rs   : req0_rs;
    dat   = e1 ? req1_data : req0_data;
    @(posedge mclk);
    #1;
    last_acc = 1'b0;
    if (rst_s) begin
      model_reset();
    end else begin
      t++;
      if (e0 || e1) begin
        last_acc = 1'b1;
        last_w   = e1;
        act      = 1'b1;
        k_acc    = t;
        dur      = P_SU + P_PW + P_HD +
                   ((!rs_w && (dat == 8'h01 || dat == 8'h02)) ? P_CLR : P_EXEC);
        own      = e1;
        m_rr     = e1;
        m_lkv    = lk;
        m_lkid   = e1;
        m_rs     = rs_w;
        m_data   = dat;
      end
    end
    d = t - k_acc;
    chk("lcd_e",    8'(lcd_e),     8'(act && d >= P_SU && d < P_SU + P_PW));
    chk("busy",     8'(busy),      8'(!m_idle()));
    chk("done0",    8'(req0_done), 8'(!rst_s && act && d == dur && !own));
    chk("done1",    8'(req1_done), 8'(!rst_s && act && d == dur && own));
    chk("lcd_rs",   8'(lcd_rs),    8'(m_rs));
    chk("lcd_data", lcd_data,      m_data);
    chk("lcd_rw",   8'(lcd_rw),    8'h00);
  endtask

  // Present one transfer on a requester until accepted (bounded), then drop valid.
  task automatic send(input bit who, input bit rs_i, input logic [7:0] dat, input bit lk);
    int n;
    if (who) begin
      req1_valid = 1'b1; req1_rs = rs_i; req1_data = dat; req1_lock = lk;
    end else begin
      req0_valid = 1'b1; req0_rs = rs_i; req0_data = dat; req0_lock = lk;
    end
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(last_acc && last_w == who) && n < 300);
    chk("send_accept", 8'(last_acc && last_w == who), 8'h01);
    if (who) req1_valid = 1'b0;
    else     req0_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00; req0_lock = 1'b0;
    req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00; req1_lock = 1'b0;
    model_reset();
    repeat (2) @(posedge mclk);
    #1;
    repeat (2) cycle();
    rst = 1'b0;

    // Power-up wait, then a plain instruction write.
    send(1'b0, 1'b0, 8'h30, 1'b0);
    repeat (20) cycle();

    // CLEAR as instruction takes the long wait; same byte as data does not.
    send(1'b0, 1'b0, 8'h01, 1'b0);
    repeat (35) cycle();
    send(1'b0, 1'b1, 8'h01, 1'b0);
    repeat (15) cycle();
    send(1'b1, 1'b0, 8'h02, 1'b0);
    repeat (35) cycle();

    // Both requesting continuously: grants alternate.
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'hA5; req0_lock = 1'b0;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h5A; req1_lock = 1'b0;
    repeat (70) cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (20) cycle();

    // Locked requester keeps the bus while the other waits.
    send(1'b1, 1'b0, 8'h80, 1'b1);
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h55; req0_lock = 1'b0;
    send(1'b1, 1'b1, 8'h41, 1'b0);
    chk("lock_second_grant", 8'(last_w), 8'h01);
    send(1'b0, 1'b1, 8'h55, 1'b0);
    chk("lock_third_grant", 8'(last_w), 8'h00);
    repeat (20) cycle();

    // Reset in the middle of the E pulse.
    send(1'b0, 1'b0, 8'h33, 1'b0);
    for (int i = 0; i < 10 && lcd_e !== 1'b1; i++) cycle();
    chk("e_before_reset", 8'(lcd_e), 8'h01);
    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // Valid withdrawn during power-up: nothing happens.
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h77; req0_lock = 1'b0;
    repeat (4) cycle();
    req0_valid = 1'b0;
    repeat (30) cycle();

    // Random traffic, occasional resets.
    for (int i = 0; i < 1500; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_rs    = 1'($urandom_range(0, 1));
      req1_rs    = 1'($urandom_range(0, 1));
      req0_lock  = ($urandom_range(0, 3) == 0);
      req1_lock  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       req0_data = 8'h01;
        1:       req0_data = 8'h02;
        default: req0_data = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       req1_data = 8'h01;
        1:       req1_data = 8'h02;
        default: req1_data = 8'($urandom);
      endcase
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (40) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
